add16_arbiter: RTL and testbench
================================

# add16_arbiter

Round-robin scheduler that shares a single 16-bit ripple adder (`full_adder_16bit`, instantiated outside this block) among up to NREQ requesters. It grants one request at a time, drives registered operands into the shared adder, and captures sum and carry-out. It returns the result with the winner's ID over a valid/ready handshake. It sits between the client blocks and the adder datapath and is the only driver of the adder inputs.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- WIDTH, 16, operand width; must match the adder instance
- IDW, $clog2(NREQ), width of the requester ID (derived localparam)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per client; held high until granted
- a_in  in  NREQ*WIDTH  operand A per client; slice i = [i*WIDTH +: WIDTH]
- b_in  in  NREQ*WIDTH  operand B per client; same packing
- cin_in  in  NREQ  carry-in per client
- gnt  out  NREQ  one-hot grant; operands of the granted client are sampled at the end of this cycle
- add_a  out  WIDTH  registered operand A to the shared adder
- add_b  out  WIDTH  registered operand B to the shared adder
- add_cin  out  1  registered carry-in to the shared adder
- add_sum  in  WIDTH  adder sum (combinational from add_*)
- add_cout  in  1  adder carry-out
- res_valid  out  1  result available
- res_id  out  IDW  index of the client that owns the result
- res_sum  out  WIDTH  captured sum
- res_cout  out  1  captured carry-out
- res_ready  in  1  consumer accepts the result

## Operation
- FSM has three states: IDLE, ISSUE, HOLD.
- **IDLE**
  - If req != 0, the arbiter picks a winner and gnt is asserted combinationally for one cycle.
  - At the edge, add_a/add_b/add_cin load the winner's slices, the winner index is stored, and the FSM moves to ISSUE.
  - If req == 0, gnt stays 0 and the FSM stays in IDLE.
- **ISSUE**
  - The adder settles during this cycle.
  - At the edge, res_sum ← add_sum, res_cout ← add_cout, res_id ← stored winner, res_valid ← 1, and the FSM moves to HOLD.
  - gnt is 0 in this state.
- **HOLD**
  - res_* are held stable while res_ready = 0; gnt is 0.
  - On res_valid & res_ready, with req != 0: the arbiter grants in the same cycle (gnt asserted, operands loaded) and the FSM moves to ISSUE; res_valid falls at the edge.
  - On res_valid & res_ready, with req == 0: res_valid falls and the FSM moves to IDLE.
- **Round-robin**
  - Pointer ptr (IDW bits) names the highest-priority client.
  - The winner is the first i with req[i] set, scanning ptr, ptr+1, … modulo NREQ.
  - After a grant to client w, ptr ← (w+1) mod NREQ.
  - ptr is unchanged when nothing is granted.
- Arithmetic is WIDTH-bit unsigned with no saturation; overflow is reported only through res_cout.
- Requests not granted stay pending. The block never drops or reorders a granted operation.
- Changes on req or a_in/b_in/cin_in outside the grant cycle have no effect on an issued operation.

## Timing
- **Reset** (synchronous): on the first edge with rst = 1:
  - FSM → IDLE, ptr → 0
  - add_a, add_b, add_cin → 0
  - res_valid, res_sum, res_cout, res_id → 0
  - gnt → 0 (combinational, while rst is high)
- **Reset mid-operation:** any in-flight or held result is discarded and no res_valid pulse occurs afterward. Clients that held req are re-arbitrated from ptr = 0 after reset deasserts.
- **Latency:** gnt in cycle T gives res_valid = 1 in cycle T+2.
- **Throughput:**
  - Back-to-back with res_ready = 1: one result every 2 cycles (grant in HOLD → ISSUE → HOLD).
  - First grant from IDLE: cycle 0 = gnt, cycle 2 = res_valid.
- **Handshake:**
  - A transfer occurs on an edge where res_valid & res_ready.
  - res_valid is never deasserted without a transfer, except by rst.
  - res_ready is ignored while res_valid = 0.
- **Simultaneous events:**
  - Handshake plus new requests in HOLD: the grant happens in the same cycle, with no idle bubble.
  - rst has priority over everything.
- **Wrap-around:** when w = NREQ-1, ptr wraps to 0.

## Test plan
- **Single request (client 0):** A=0xCCCC, B=0x3333, cin=0 → gnt=0001 for one cycle; two cycles later res_valid=1, res_sum=0xFFFF, res_cout=0, res_id=0.
- **Carry-in and carry-out (client 2):** A=0xF0F0, B=0x0F0F, cin=1 → res_sum=0x0000, res_cout=1, res_id=2. Also 0xFFFF+0x0001, cin=0 → 0x0000, cout=1.
- **Round-robin with all four clients requesting continuously and res_ready=1:**
  - Grant order is 0,1,2,3,0,1, with one result every 2 cycles.
  - Then hold only req[1] and req[3] with ptr=2: the next grant goes to 3, then 1.
- **Backpressure:** hold res_ready=0 for 5 cycles after res_valid rises → res_valid, res_sum, res_id and res_cout are unchanged and gnt stays 0. Raise res_ready → transfer occurs, and a pending request is granted in the same cycle.
- **Reset mid-operation:** assert rst in the ISSUE cycle → the next cycle shows res_valid=0, add_a=0 and ptr=0; no result for that request appears afterward. After rst falls, client 0 wins first even if ptr was nonzero before reset.
- **Operand change after grant:** change a_in for the granted client in the ISSUE cycle → res_sum still reflects the operands sampled at the grant.

Source files
------------

// File: rtl/add16_arbiter.sv
// Round-robin scheduler sharing one external WIDTH-bit adder among NREQ clients.
// One operation in flight at a time; results return with the owner's ID over valid/ready.
module add16_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    input  logic [NREQ-1:0]           cin_in,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    output logic                      add_cin,
    input  logic [WIDTH-1:0]          add_sum,
    input  logic                      add_cout,
    output logic                      res_valid,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [WIDTH-1:0]          res_sum,
    output logic                      res_cout,
    input  logic                      res_ready
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_win;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic               r_add_cin;
    logic               r_res_valid;
    logic [IDW-1:0]     r_res_id;
    logic [WIDTH-1:0]   r_res_sum;
    logic               r_res_cout;

    logic               w_any;
    logic [IDW-1:0]     w_winner;
    logic [IDW-1:0]     w_scan;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [NREQ-1:0]    w_onehot;
    logic               w_load;
    logic               w_capture;
    logic               w_release;

    logic [WIDTH-1:0]   w_a_arr [NREQ];
    logic [WIDTH-1:0]   w_b_arr [NREQ];

    // Unpack the flat per-client operand buses into arrays indexable by winner.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
        assign w_b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
    end

    // Client index k positions after base, modulo NREQ (base and k are both < NREQ).
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // First requester at or after the priority pointer.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_scan = rr_idx(r_ptr, k);
            if (!w_any && req[w_scan]) begin
                w_any    = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    assign w_onehot  = NREQ'(1) << w_winner;
    assign w_ptr_nxt = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new grant is taken from IDLE, or from HOLD in the same cycle the result is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_release = 1'b1;
                    if (w_any) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            w_load = 1'b0;
        end
    end

    assign gnt = w_load ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_win       <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
        end else begin
            if (w_load) begin
                r_add_a   <= w_a_arr[w_winner];
                r_add_b   <= w_b_arr[w_winner];
                r_add_cin <= cin_in[w_winner];
                r_win     <= w_winner;
                r_ptr     <= w_ptr_nxt;
            end
            // Adder output has settled by the end of ISSUE.
            if (w_capture) begin
                r_res_sum   <= add_sum;
                r_res_cout  <= add_cout;
                r_res_id    <= r_win;
                r_res_valid <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;

endmodule

// File: tb/tb_add16_arbiter.sv
// Scoreboard bench for add16_arbiter: directed scenarios plus random traffic,
// with a round-robin reference model and an external adder model.
module tb_add16_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   a_in;
    logic [NREQ*WIDTH-1:0]   b_in;
    logic [NREQ-1:0]         cin_in;
    logic [NREQ-1:0]         gnt;
    logic [WIDTH-1:0]        add_a;
    logic [WIDTH-1:0]        add_b;
    logic                    add_cin;
    logic [WIDTH-1:0]        add_sum;
    logic                    add_cout;
    logic                    res_valid;
    logic [IDW-1:0]          res_id;
    logic [WIDTH-1:0]        res_sum;
    logic                    res_cout;
    logic                    res_ready;

    always #5 clk = ~clk;

    // The shared ripple adder lives outside the arbiter.
    assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

    add16_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ready (res_ready)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    exp_t            sb[$];
    int              lat_q[$];
    int              vectors    = 0;
    int              miscompares = 0;
    int              cyc        = 0;
    int              m_ptr      = 0;
    int              last_gcyc  = -10;
    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic            prev_rst   = 1'b1;
    logic [WIDTH-1:0] prev_sum  = '0;
    logic [IDW-1:0]  prev_id    = '0;
    logic            prev_cout  = 1'b0;
    logic [NREQ-1:0] seen_gnt   = '0;
    int              exp_order[6] = '{0, 1, 2, 3, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: awaited event never came (cycle %0d)", name, cyc);
    endtask

    // Reference round-robin: first requester scanning from p upward, modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: predicts grants, pushes expected results, pops on each transfer.
    always @(negedge clk) begin
        if (rst) begin
            chk("gnt_during_rst", 32'(gnt), 32'd0);
        end else begin
            bit due;
            due = (req != '0) && (!res_valid || res_ready) && (cyc != last_gcyc + 1);
            chk("grant_due", 32'(gnt != '0), 32'(due));
            if (gnt != '0) begin
                int             w;
                exp_t           e;
                logic [WIDTH:0] s;
                w = rr_pick(req, m_ptr);
                chk("gnt_rr", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
                if (w >= 0) begin
                    s = 17'(a_in[w*WIDTH +: WIDTH]) + 17'(b_in[w*WIDTH +: WIDTH]) + 17'(cin_in[w]);
                    e.id   = w;
                    e.sum  = s[WIDTH-1:0];
                    e.cout = s[WIDTH];
                    sb.push_back(e);
                    lat_q.push_back(cyc);
                    m_ptr = (w + 1) % NREQ;
                end
                last_gcyc = cyc;
            end
            if (res_valid && !prev_valid) begin
                if (lat_q.size() == 0) begin
                    timeout_fail("spurious_res_valid");
                end else begin
                    int g;
                    g = lat_q.pop_front();
                    chk("latency", 32'(cyc - g), 32'd2);
                end
            end
            if (!prev_rst && prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_sum",   32'(res_sum),   32'(prev_sum));
                chk("hold_id",    32'(res_id),    32'(prev_id));
                chk("hold_cout",  32'(res_cout),  32'(prev_cout));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_result");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id",   32'(res_id),   32'(e.id));
                    chk("sb_sum",  32'(res_sum),  32'(e.sum));
                    chk("sb_cout", 32'(res_cout), 32'(e.cout));
                end
            end
        end
        prev_valid = res_valid;
        prev_ready = res_ready;
        prev_rst   = rst;
        prev_sum   = res_sum;
        prev_id    = res_id;
        prev_cout  = res_cout;
        seen_gnt   = rst ? '0 : gnt;
    end

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
        cin_in[i]              = c;
    endtask

    task automatic wait_gnt(input string name, output logic [NREQ-1:0] g, output int gc);
        g  = '0;
        gc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g  = gnt;
                gc = cyc;
                break;
            end
        end
        if (g == '0) timeout_fail(name);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !res_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input string name);
        logic [NREQ-1:0] g;
        int              gc;
        for (int n = 0; n < 16 && req != '0; n++) begin
            wait_gnt(name, g, gc);
            if (g == '0) break;
            @(posedge clk);
            #1;
            req = req & ~g;
        end
    endtask

    task automatic run_one(input string name, input int i, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic c,
                           input logic [WIDTH-1:0] es, input logic ec);
        logic [NREQ-1:0] g;
        int              gc;
        set_op(i, a, b, c);
        req = NREQ'(1) << i;
        wait_gnt({name, "_gnt_wait"}, g, gc);
        chk({name, "_gnt"}, 32'(g), 32'd1 << i);
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        chk({name, "_gnt_pulse"}, 32'(gnt), 32'd0);
        chk({name, "_issue_valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(res_valid), 32'd1);
        chk({name, "_sum"},   32'(res_sum),   32'(es));
        chk({name, "_cout"},  32'(res_cout),  32'(ec));
        chk({name, "_id"},    32'(res_id),    32'(i));
        drain({name, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] g;
        int              gc;
        int              pgc;
        logic [WIDTH-1:0] bp_sum;

        rst = 1'b1; req = '0; a_in = '0; b_in = '0; cin_in = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sum",   32'(res_sum),   32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_res_cout",  32'(res_cout),  32'd0);
        chk("rst_add_a",     32'(add_a),     32'd0);
        chk("rst_add_b",     32'(add_b),     32'd0);
        chk("rst_add_cin",   32'(add_cin),   32'd0);
        rst = 1'b0;
        res_ready = 1'b1;

        // All four clients requesting continuously.
        for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
        req = 4'hF;
        pgc = 0;
        for (int k = 0; k < 6; k++) begin
            wait_gnt("rr_wait", g, gc);
            chk("rr_order", 32'(g), 32'd1 << exp_order[k]);
            if (k > 0) chk("rr_spacing", 32'(gc - pgc), 32'd2);
            pgc = gc;
            @(posedge clk);
            #1;
        end
        req = 4'b1010;
        wait_gnt("rr_skip_wait", g, gc);
        chk("rr_skip_to_3", 32'(g), 32'b1000);
        @(posedge clk);
        #1;
        req = 4'b0010;
        wait_gnt("rr_then_wait", g, gc);
        chk("rr_then_1", 32'(g), 32'b0010);
        @(posedge clk);
        #1;
        req = '0;
        drain("rr_drain");

        run_one("single_c0", 0, 16'hCCCC, 16'h3333, 1'b0, 16'hFFFF, 1'b0);
        run_one("carry_c2",  2, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1);
        run_one("ovf_c3",    3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

        // Backpressure with a request pending behind the held result.
        res_ready = 1'b0;
        set_op(0, 16'h1111, 16'h2222, 1'b1);
        req = 4'b0001;
        wait_gnt("bp_wait", g, gc);
        chk("bp_gnt", 32'(g), 32'b0001);
        @(posedge clk);
        #1;
        set_op(3, 16'h8000, 16'h8000, 1'b0);
        req = 4'b1000;
        @(negedge clk);
        chk("bp_issue_no_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("bp_valid", 32'(res_valid), 32'd1);
        chk("bp_sum",   32'(res_sum),   32'h3334);
        chk("bp_id",    32'(res_id),    32'd0);
        bp_sum = res_sum;
        repeat (5) begin
            @(negedge clk);
            chk("bp_held_valid", 32'(res_valid), 32'd1);
            chk("bp_held_sum",   32'(res_sum),   32'(bp_sum));
            chk("bp_held_id",    32'(res_id),    32'd0);
            chk("bp_held_cout",  32'(res_cout),  32'd0);
            chk("bp_held_gnt",   32'(gnt),       32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_gnt", 32'(gnt), 32'b1000);
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_sum",  32'(res_sum),  32'h0000);
        chk("bp_next_cout", 32'(res_cout), 32'd1);
        chk("bp_next_id",   32'(res_id),   32'd3);
        drain("bp_drain");

        // Reset while an operation is in ISSUE.
        set_op(1, 16'h0F00, 16'h00F0, 1'b0);
        set_op(2, 16'h0ABC, 16'h0001, 1'b0);
        req = 4'b0110;
        wait_gnt("rst_pre_wait", g, gc);
        chk("rst_pre_gnt", 32'(g), 32'b0010);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_op(0, 16'h0001, 16'h0002, 1'b0);
        req = 4'b0111;
        sb.delete();
        lat_q.delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_add_a", 32'(add_a),     32'd0);
        chk("rst_mid_add_b", 32'(add_b),     32'd0);
        chk("rst_mid_gnt",   32'(gnt),       32'd0);
        @(negedge clk);
        chk("rst_mid_valid2", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_gnt("rst_post_wait", g, gc);
        chk("rst_ptr_zero", 32'(g), 32'b0001);
        @(posedge clk);
        #1;
        req = req & ~g;
        serve("rst_serve");
        drain("rst_drain");

        // Operands changed after the grant must not affect the result.
        set_op(2, 16'h1234, 16'h1111, 1'b0);
        req = 4'b0100;
        wait_gnt("opchg_wait", g, gc);
        @(posedge clk);
        #1;
        set_op(2, 16'hFFFF, 16'hFFFF, 1'b1);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("opchg_valid", 32'(res_valid), 32'd1);
        chk("opchg_sum",   32'(res_sum),   32'h2345);
        chk("opchg_cout",  32'(res_cout),  32'd0);
        drain("opchg_drain");

        // Random traffic with random backpressure.
        repeat (600) begin
            @(posedge clk);
            #1;
            req = req & ~seen_gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
                        req[i] = 1'b1;
                    end else if ($urandom_range(0, 1) == 0) begin
                        set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
                    end
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        req = req & ~seen_gnt;
        res_ready = 1'b1;
        serve("rand_serve");
        drain("rand_drain");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
